// File: rtl/assembly_pass_sequencer.sv
// Two-pass assembler sequencer: streams text BRAM bytes to the interpreters,
// owns the byte PC and reports clean completion or the failing instruction line.
package assembly_pass_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PC_MAPPING = 2'd1,
    ASSEMBLING = 2'd2,
    DONE       = 2'd3
  } assembler_state_t;
endpackage

module assembly_pass_sequencer
  import assembly_pass_pkg::*;
#(
  parameter int NUMBER_LINES = 256,
  parameter int TEXT_DEPTH   = 4096,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  output logic [$clog2(TEXT_DEPTH)-1:0]   text_addr,
  input  logic [7:0]                      text_data,
  output logic [7:0]                      incoming_character,
  output logic                            new_character,
  output logic                            new_line,
  output logic                            valid_data,
  output logic [$clog2(NUMBER_LINES)+1:0] pc,
  output assembler_state_t                assembler_state,
  input  logic                            sub_error_in,
  output logic                            line_done,
  output logic                            done_out,
  output logic                            error_out,
  output logic [$clog2(NUMBER_LINES)-1:0] error_line
);
  localparam int AW = $clog2(TEXT_DEPTH);
  localparam int LW = $clog2(NUMBER_LINES);
  localparam int PW = LW + 2;
  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [PW-1:0] PC_LAST   = PW'((NUMBER_LINES - 1) * 4);
  localparam logic [AW-1:0] ADDR_LAST = AW'(TEXT_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_GAP, S_NEWLINE, S_PASS_END, S_DONE, S_FAIL
  } seq_state_t;

  typedef enum logic [1:0] {L_BLANK, L_INSTR, L_LABEL} line_kind_t;

  seq_state_t       r_state, w_state_nxt;
  assembler_state_t r_asm_state;
  line_kind_t       r_kind;
  logic [AW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_pc;
  logic [CW-1:0]    r_wait_cnt;
  logic [7:0]       r_char;
  logic [LW-1:0]    r_error_line;
  logic             r_seen, r_line_any, r_final;

  logic w_streaming, w_is_nl, w_is_nul, w_is_space, w_is_alpha, w_last_addr;
  logic w_instr, w_overflow;
  logic w_start_pass, w_next_pass, w_capture, w_line_end, w_sub_fail, w_ovf_fail;

  assign w_streaming = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ISSUE) ||
                       (r_state == S_GAP) || (r_state == S_NEWLINE);
  assign w_is_nl     = (text_data == 8'h0A);
  assign w_is_nul    = (text_data == 8'h00);
  assign w_is_space  = (text_data == 8'h20) || (text_data == 8'h09);
  assign w_is_alpha  = ((text_data >= 8'h61) && (text_data <= 8'h7A)) ||
                       ((text_data >= 8'h41) && (text_data <= 8'h5A));
  assign w_last_addr = (r_rd_ptr == ADDR_LAST);
  assign w_instr     = (r_kind == L_INSTR);
  assign w_overflow  = w_instr && (r_pc == PC_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_start_pass = 1'b0;
    w_next_pass  = 1'b0;
    w_capture    = 1'b0;
    w_line_end   = 1'b0;
    w_sub_fail   = 1'b0;
    w_ovf_fail   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_in) begin
          w_state_nxt  = S_FETCH;
          w_start_pass = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_capture = 1'b1;
          // A terminator on an empty line just ends the pass; no spurious new_line.
          if (w_is_nul && !r_line_any)  w_state_nxt = S_PASS_END;
          else if (w_is_nl || w_is_nul) w_state_nxt = S_NEWLINE;
          else                          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = r_final ? S_NEWLINE : S_FETCH;
      S_NEWLINE: begin
        w_line_end = 1'b1;
        if (w_overflow) begin
          w_state_nxt = S_FAIL;
          w_ovf_fail  = 1'b1;
        end else begin
          w_state_nxt = r_final ? S_PASS_END : S_FETCH;
        end
      end
      S_PASS_END: begin
        if (r_asm_state == PC_MAPPING) begin
          w_state_nxt = S_FETCH;
          w_next_pass = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_streaming && sub_error_in) begin
      w_state_nxt = S_FAIL;
      w_sub_fail  = 1'b1;
      w_capture   = 1'b0;
      w_line_end  = 1'b0;
      w_ovf_fail  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_asm_state  <= IDLE;
      r_kind       <= L_BLANK;
      r_rd_ptr     <= '0;
      r_pc         <= '0;
      r_wait_cnt   <= '0;
      r_char       <= '0;
      r_error_line <= '0;
      r_seen       <= 1'b0;
      r_line_any   <= 1'b0;
      r_final      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH)
        r_wait_cnt <= CW'(RAM_LATENCY - 1);
      else if ((r_state == S_WAIT) && (r_wait_cnt != '0))
        r_wait_cnt <= r_wait_cnt - CW'(1);
      if (w_capture) begin
        if (!w_last_addr)            r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_is_nul || w_last_addr) r_final  <= 1'b1;
        if (!w_is_nl && !w_is_nul) begin
          r_char     <= text_data;
          r_line_any <= 1'b1;
          if (!r_seen && !w_is_space) begin
            r_seen <= 1'b1;
            r_kind <= w_is_alpha ? L_INSTR : ((text_data == 8'h27) ? L_LABEL : L_BLANK);
          end
        end
      end
      // Label and blank lines keep pc, so a label binds to the next instruction.
      if (w_line_end) begin
        r_seen     <= 1'b0;
        r_line_any <= 1'b0;
        r_kind     <= L_BLANK;
        if (w_instr && !w_overflow) r_pc <= r_pc + PW'(4);
      end
      if (w_sub_fail) r_error_line <= r_pc[PW-1:2];
      if (w_ovf_fail) r_error_line <= LW'(NUMBER_LINES - 1);
      if (w_next_pass) begin
        r_asm_state <= ASSEMBLING;
        r_rd_ptr    <= '0;
        r_pc        <= '0;
        r_final     <= 1'b0;
      end
      if ((r_state == S_PASS_END) && (w_state_nxt == S_DONE)) r_asm_state <= DONE;
      if (w_start_pass) begin
        r_asm_state  <= PC_MAPPING;
        r_rd_ptr     <= '0;
        r_pc         <= '0;
        r_final      <= 1'b0;
        r_seen       <= 1'b0;
        r_line_any   <= 1'b0;
        r_kind       <= L_BLANK;
        r_error_line <= '0;
      end
    end
  end

  assign text_addr          = r_rd_ptr;
  assign incoming_character = r_char;
  assign new_character      = (r_state == S_ISSUE);
  assign new_line           = (r_state == S_NEWLINE);
  assign valid_data         = w_streaming;
  assign pc                 = r_pc;
  assign assembler_state    = r_asm_state;
  assign line_done          = (r_state == S_NEWLINE) && w_instr && (r_asm_state == ASSEMBLING);
  assign done_out           = (r_state == S_DONE);
  assign error_out          = (r_state == S_FAIL);
  assign error_line         = r_error_line;

endmodule

// File: tb/tb_assembly_pass_sequencer.sv
// Directed bench for assembly_pass_sequencer: table of text programs with
// hand-computed stream counts and final status, plus reset-mid-pass sequence.
module tb_assembly_pass_sequencer;
  import assembly_pass_pkg::*;

  localparam int NL = 4;
  localparam int TD = 256;
  localparam int RL = 2;
  localparam int BUDGET = 3000;

  logic             clk_sys = 1'b0;
  logic             rst_in = 1'b1;
  logic             start_in = 1'b0;
  logic             sub_error_in = 1'b0;
  logic [7:0]       text_addr;
  logic [7:0]       text_data;
  logic [7:0]       incoming_character;
  logic             new_character, new_line, valid_data;
  logic [3:0]       pc;
  assembler_state_t assembler_state;
  logic             line_done, done_out, error_out;
  logic [1:0]       error_line;

  assembly_pass_sequencer #(
    .NUMBER_LINES(NL), .TEXT_DEPTH(TD), .RAM_LATENCY(RL)
  ) dut (
    .clk_in(clk_sys), .rst_in(rst_in), .start_in(start_in),
    .text_addr(text_addr), .text_data(text_data),
    .incoming_character(incoming_character), .new_character(new_character),
    .new_line(new_line), .valid_data(valid_data), .pc(pc),
    .assembler_state(assembler_state), .sub_error_in(sub_error_in),
    .line_done(line_done), .done_out(done_out), .error_out(error_out),
    .error_line(error_line)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] mem [TD];
  logic [7:0] pipe [RL];
  always @(posedge clk_sys) begin
    pipe[0] <= mem[text_addr];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign text_data = pipe[RL-1];

  typedef struct packed {
    int err_line;   // ASSEMBLING line index on which sub_error_in is raised, -1 none
    int start_mid;
    int n_chr;
    int n_nl;
    int n_ld;
    int ld_pc0;
    int ld_pc1;
    int pc;
    int done;
    int err;
    int err_line_exp;
    int asm_fin;
    int st_code;    // assembler_state changes, base-4 digits in order
  } vec_t;

  vec_t  vecs [5];
  string txt  [5];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    t_chr [3];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_text(input string s);
    for (int i = 0; i < TD; i++) mem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  task automatic check_reset(input string tg);
    check({tg, " incoming_character"}, int'(incoming_character), 0);
    check({tg, " new_character"}, int'(new_character), 0);
    check({tg, " new_line"}, int'(new_line), 0);
    check({tg, " valid_data"}, int'(valid_data), 0);
    check({tg, " pc"}, int'(pc), 0);
    check({tg, " assembler_state"}, int'(assembler_state), int'(IDLE));
    check({tg, " line_done"}, int'(line_done), 0);
    check({tg, " done_out"}, int'(done_out), 0);
    check({tg, " error_out"}, int'(error_out), 0);
    check({tg, " error_line"}, int'(error_line), 0);
    check({tg, " text_addr"}, int'(text_addr), 0);
  endtask

  task automatic run_test(input int id);
    vec_t  v;
    string tg;
    int    n_chr, n_nl, n_nl_asm, n_ld, p0, p1, bad, code, prev, cyc;
    bit    fin;
    v = vecs[id];
    tg = $sformatf("T%0d", id + 1);
    load_text(txt[id]);
    n_chr = 0; n_nl = 0; n_nl_asm = 0; n_ld = 0; p0 = -1; p1 = -1;
    bad = 0; code = 0; cyc = 0; fin = 1'b0;
    prev = int'(assembler_state);
    start_in = 1'b1;
    @(negedge clk_sys);
    start_in = 1'b0;
    while (!fin && cyc < BUDGET) begin
      if (v.start_mid != 0) start_in = (cyc == 10);
      if (int'(assembler_state) != prev) begin
        prev = int'(assembler_state);
        code = code * 4 + prev;
      end
      if (new_character && new_line) bad++;
      if (line_done && !new_line) bad++;
      if (new_character) begin
        if (n_chr < 3) t_chr[n_chr] = cyc;
        n_chr++;
        if (v.err_line >= 0 && assembler_state == ASSEMBLING && n_nl_asm == v.err_line)
          sub_error_in = 1'b1;
      end
      if (new_line) begin
        n_nl++;
        if (assembler_state == ASSEMBLING) n_nl_asm++;
      end
      if (line_done) begin
        if (n_ld == 0) p0 = int'(pc);
        else if (n_ld == 1) p1 = int'(pc);
        n_ld++;
      end
      if (done_out || error_out) fin = 1'b1;
      else begin
        @(negedge clk_sys);
        cyc++;
      end
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no done/error within %0d cycles", tg, BUDGET);
    end
    start_in = 1'b0;
    sub_error_in = 1'b0;
    check({tg, " valid_at_end"}, int'(valid_data), 0);
    check({tg, " chars"}, n_chr, v.n_chr);
    check({tg, " new_lines"}, n_nl, v.n_nl);
    check({tg, " line_done_cnt"}, n_ld, v.n_ld);
    check({tg, " line_done_pc0"}, p0, v.ld_pc0);
    check({tg, " line_done_pc1"}, p1, v.ld_pc1);
    check({tg, " final_pc"}, int'(pc), v.pc);
    check({tg, " done_out"}, int'(done_out), v.done);
    check({tg, " error_out"}, int'(error_out), v.err);
    check({tg, " error_line"}, int'(error_line), v.err_line_exp);
    check({tg, " assembler_state"}, int'(assembler_state), v.asm_fin);
    check({tg, " state_sequence"}, code, v.st_code);
    check({tg, " strobe_collisions"}, bad, 0);
  endtask

  initial begin
    //                 err mid chr nl ld p0  p1  pc dn er el fin code
    txt[0]  = "add\n";
    vecs[0] = '{-1, 0,  6, 2, 1, 0, -1,  4, 1, 0, 0, 3, 27};
    txt[1]  = "'lp'\nadd\nbne 'lp'\n";
    vecs[1] = '{-1, 1, 30, 6, 2, 0,  4,  8, 1, 0, 0, 3, 27};
    txt[2]  = "  \n\nadd\n";
    vecs[2] = '{-1, 0, 10, 6, 1, 0, -1,  4, 1, 0, 0, 3, 27};
    txt[3]  = "add\nsub\n";
    vecs[3] = '{ 1, 0, 10, 3, 1, 0, -1,  4, 0, 1, 1, 2,  6};
    txt[4]  = "a\nb\nc\nd\ne\n";
    vecs[4] = '{-1, 0,  4, 4, 0, -1, -1, 12, 0, 1, 3, 1,  1};

    load_text("");
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset("reset");
    rst_in = 1'b0;
    @(negedge clk_sys);

    for (int i = 0; i < 5; i++) run_test(i);

    // Reset while the first character is still in the BRAM wait window.
    rst_in = 1'b1;
    @(negedge clk_sys);
    rst_in = 1'b0;
    load_text(txt[0]);
    start_in = 1'b1;
    @(negedge clk_sys);
    start_in = 1'b0;
    @(negedge clk_sys);
    check("T6 started_before_reset", int'(assembler_state), int'(PC_MAPPING));
    rst_in = 1'b1;
    @(negedge clk_sys);
    check_reset("T6 mid_reset");
    rst_in = 1'b0;
    @(negedge clk_sys);
    run_test(0);
    check("T6 char_spacing_1", t_chr[1] - t_chr[0], 1 + RL + 2);
    check("T6 char_spacing_2", t_chr[2] - t_chr[1], 1 + RL + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
